// File: rtl/axi_hp_pkg.sv
// Shared definitions for the HP write responder.
// Contents:
//   BURST_*  AXI3 awburst encodings
//   RESP_*   AXI3 bresp encodings
//   state_t  write FSM states
package axi_hp_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/bram_byte_we.sv
// Simple dual-port RAM: one write port with per-byte enables, one read port
// with a registered output. Each byte lane is its own array so that every
// lane maps onto a plain single-write BRAM column.
// Ports:
//   clk    clock
//   rst    async active-high reset, clears the read register only
//   we     per-byte write enable
//   waddr  write word index
//   wdata  write data
//   raddr  read word index
//   rdata  mem[raddr] one cycle later; a same-cycle write returns old data
module bram_byte_we #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH/8-1:0]  we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  localparam int NB = DATA_WIDTH / 8;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_lane_reg;

      always_ff @(posedge clk) begin
        if (we[gi]) begin
          mem[waddr] <= wdata[gi*8 +: 8];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_lane_reg <= '0;
        end else begin
          rd_lane_reg <= mem[raddr];
        end
      end

      assign rdata[gi*8 +: 8] = rd_lane_reg;
    end
  endgenerate

endmodule

// File: rtl/axi_hp_wr_responder.sv
// AXI3 write-only slave terminating a DMA write channel into PL BRAM, used
// in place of the PS HP0 port. A side read port exposes captured words.
// Ports:
//   axi_aclk / axi_areset   clock, async active-high reset
//   s_axi_aw*               write address channel (awprot/awcache ignored)
//   s_axi_w*                write data channel
//   s_axi_b*                write response channel
//   rd_addr / rd_data       side read port, 1-cycle latency
//   burst_cnt               completed bursts, wraps
//   err_cnt                 non-OKAY bursts, saturates
module axi_hp_wr_responder
  import axi_hp_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 64,
  parameter int          MEM_DEPTH  = 1024,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                         axi_aclk,
  input  logic                         axi_areset,
  input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
  input  logic [3:0]                   s_axi_awlen,
  input  logic [2:0]                   s_axi_awsize,
  input  logic [1:0]                   s_axi_awburst,
  input  logic [2:0]                   s_axi_awprot,
  input  logic [3:0]                   s_axi_awcache,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [DATA_WIDTH-1:0]        s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]      s_axi_wstrb,
  input  logic                         s_axi_wlast,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [$clog2(MEM_DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic [31:0]                  burst_cnt,
  output logic [15:0]                  err_cnt
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int LOG_NB = $clog2(NB);
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [3:0]            len_reg, beat_reg;
  logic [2:0]            size_reg;
  logic [1:0]            burst_reg;
  logic                  slverr_reg, decerr_reg;
  logic [31:0]           burst_cnt_reg;
  logic [15:0]           err_cnt_reg;

  logic aw_fire, w_fire, b_fire;
  logic [ADDR_WIDTH-1:0] byte_off, word_off, addr_inc;
  logic in_range, size_ok, burst_ok, last_beat, page_cross;
  logic beat_slverr, beat_decerr;
  logic [NB-1:0] mem_we;

  assign aw_fire = s_axi_awvalid & s_axi_awready;
  assign w_fire  = s_axi_wvalid & s_axi_wready;
  assign b_fire  = s_axi_bvalid & s_axi_bready;

  // Address decode for the current beat
  assign byte_off = addr_reg - ADDR_WIDTH'(BASE_ADDR);
  assign word_off = byte_off >> LOG_NB;
  assign in_range = (addr_reg >= ADDR_WIDTH'(BASE_ADDR)) &&
                    (word_off < ADDR_WIDTH'(MEM_DEPTH));
  assign size_ok  = size_reg <= 3'(LOG_NB);
  assign burst_ok = (burst_reg == BURST_FIXED) || (burst_reg == BURST_INCR);
  assign last_beat = beat_reg == len_reg;
  assign addr_inc  = addr_reg + (ADDR_WIDTH'(1) << size_reg);
  // Only a step to a following beat can cross a page; the step after the
  // final beat is never used.
  assign page_cross = (burst_reg == BURST_INCR) && !last_beat &&
                      (addr_inc[ADDR_WIDTH-1:12] != addr_reg[ADDR_WIDTH-1:12]);

  assign beat_slverr = !burst_ok || !size_ok || (s_axi_wlast != last_beat) || page_cross;
  assign beat_decerr = !in_range;
  assign mem_we = (w_fire && burst_ok && size_ok && in_range) ? s_axi_wstrb : '0;

  bram_byte_we #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH)
  ) u_mem (
    .clk   (axi_aclk),
    .rst   (axi_areset),
    .we    (mem_we),
    .waddr (word_off[IDX_W-1:0]),
    .wdata (s_axi_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      len_reg       <= '0;
      beat_reg      <= '0;
      size_reg      <= '0;
      burst_reg     <= '0;
      slverr_reg    <= 1'b0;
      decerr_reg    <= 1'b0;
      burst_cnt_reg <= '0;
      err_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (aw_fire) begin
        addr_reg   <= s_axi_awaddr;
        len_reg    <= s_axi_awlen;
        size_reg   <= s_axi_awsize;
        burst_reg  <= s_axi_awburst;
        beat_reg   <= '0;
        slverr_reg <= 1'b0;
        decerr_reg <= 1'b0;
      end else if (w_fire) begin
        beat_reg   <= beat_reg + 4'd1;
        slverr_reg <= slverr_reg | beat_slverr;
        decerr_reg <= decerr_reg | beat_decerr;
        if (burst_reg == BURST_INCR) begin
          addr_reg <= addr_inc;
        end
      end
      if (b_fire) begin
        burst_cnt_reg <= burst_cnt_reg + 32'd1;
        if ((s_axi_bresp != RESP_OKAY) && (err_cnt_reg != 16'hFFFF)) begin
          err_cnt_reg <= err_cnt_reg + 16'd1;
        end
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = RESP_OKAY;
    case (state_reg)
      IDLE: begin
        s_axi_awready = 1'b1;
        if (s_axi_awvalid) state_next = DATA;
      end
      DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && last_beat) state_next = RESP;
      end
      RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = decerr_reg ? RESP_DECERR : (slverr_reg ? RESP_SLVERR : RESP_OKAY);
        if (s_axi_bready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign burst_cnt = burst_cnt_reg;
  assign err_cnt   = err_cnt_reg;

  logic unused_sideband;
  assign unused_sideband = ^{s_axi_awprot, s_axi_awcache};

endmodule

// File: tb/tb_axi_hp_wr_responder.sv
module tb_axi_hp_wr_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic [3:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [31:0] burst_cnt;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  axi_hp_wr_responder dut (
    .axi_aclk      (clk),
    .axi_areset    (rst),
    .s_axi_awaddr  (awaddr),
    .s_axi_awlen   (awlen),
    .s_axi_awsize  (awsize),
    .s_axi_awburst (awburst),
    .s_axi_awprot  (3'd0),
    .s_axi_awcache (4'd0),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wlast   (wlast),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .burst_cnt     (burst_cnt),
    .err_cnt       (err_cnt)
  );

  int n_checks = 0;
  int n_fail = 0;
  int exp_bursts = 0;
  int exp_errs = 0;
  logic [63:0] bdata [16];
  logic [1:0]  bresp_q [$];
  logic [63:0] rd_q [$];

  // AW handshake, bounded wait on awready
  task automatic send_aw(input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    n_checks++;
    if (n >= 50) begin n_fail++; $display("FAIL aw_timeout awready=%b required 1", awready); end
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  // One W beat, bounded wait on wready
  task automatic send_w(input logic [63:0] d, input logic [7:0] s, input logic l);
    int n;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    n = 0;
    while (wready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin n_checks++; n_fail++; $display("FAIL w_timeout wready=%b required 1", wready); end
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic do_burst(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [7:0] strb, input int wlast_beat,
                          input logic [1:0] exp_resp, input int hold);
    int n;
    logic [1:0] er;
    bresp_q.push_back(exp_resp);
    send_aw(addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      wdata = bdata[i]; wstrb = strb; wlast = (i == wlast_beat); wvalid = 1'b1;
      n = 0;
      while (wready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin n_checks++; n_fail++; $display("FAIL w_timeout beat=%0d", i); end
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (bvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    er = bresp_q.pop_front();
    n_checks++;
    if (bvalid !== 1'b1) begin n_fail++; $display("FAIL b_timeout bvalid=%b required 1", bvalid); end
    n_checks++;
    if (bresp !== er) begin n_fail++; $display("FAIL bresp addr=%h got=%0d required=%0d", addr, bresp, er); end
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      n_checks++;
      if (bvalid !== 1'b1 || bresp !== er || awready !== 1'b0) begin
        n_fail++;
        $display("FAIL b_hold cycle=%0d bvalid=%b bresp=%0d awready=%b required 1/%0d/0", k, bvalid, bresp, awready, er);
      end
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    exp_bursts++;
    if (er != 2'd0 && exp_errs < 65535) exp_errs++;
    n_checks++;
    if (burst_cnt !== 32'(exp_bursts) || err_cnt !== 16'(exp_errs)) begin
      n_fail++;
      $display("FAIL counters burst_cnt=%0d err_cnt=%0d required %0d/%0d", burst_cnt, err_cnt, exp_bursts, exp_errs);
    end
    n_checks++;
    if (awready !== 1'b1 || bvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_b awready=%b bvalid=%b required 1/0", awready, bvalid);
    end
    $display("burst addr=%h len=%0d size=%0d type=%0d bresp=%0d burst_cnt=%0d err_cnt=%0d",
             addr, len, size, burst, er, burst_cnt, err_cnt);
  endtask

  task automatic check_mem(input int idx, input logic [63:0] exp);
    logic [63:0] e;
    rd_q.push_back(exp);
    rd_addr = 10'(idx);
    @(negedge clk);
    e = rd_q.pop_front();
    n_checks++;
    if (rd_data !== e) begin n_fail++; $display("FAIL mem[%0d] got=%h required=%h", idx, rd_data, e); end
    else $display("read mem[%0d]=%h", idx, rd_data);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0 || bresp !== 2'd0 ||
        burst_cnt !== 32'd0 || err_cnt !== 16'd0 || rd_data !== 64'd0) begin
      n_fail++;
      $display("FAIL reset aw=%b w=%b b=%b bresp=%0d bc=%0d ec=%0d rd=%h required 1/0/0/0/0/0/0",
               awready, wready, bvalid, bresp, burst_cnt, err_cnt, rd_data);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("reset done");
  endtask

  task automatic test_incr();
    for (int i = 0; i < 16; i++) bdata[i] = 64'(i);
    do_burst(32'h0, 4'd15, 3'd3, 2'd1, 8'hFF, 15, 2'd0, 0);
    for (int i = 0; i < 16; i += 5) check_mem(i, 64'(i));
    check_mem(15, 64'd15);
  endtask

  task automatic test_fixed();
    bdata[0] = 64'hAAAA; bdata[1] = 64'hBBBB; bdata[2] = 64'hCCCC; bdata[3] = 64'hDDDD;
    do_burst(32'h40, 4'd3, 3'd3, 2'd0, 8'hFF, 3, 2'd0, 0);
    check_mem(8, 64'hDDDD);
    check_mem(9, 64'd9);
  endtask

  task automatic test_strobe();
    bdata[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_burst(32'h960, 4'd0, 3'd3, 2'd0, 8'hFF, 0, 2'd0, 0);
    bdata[0] = 64'h1111_2222_3333_4444;
    do_burst(32'h960, 4'd0, 3'd3, 2'd1, 8'h0F, 0, 2'd0, 0);
    check_mem(300, 64'hFFFF_FFFF_3333_4444);
  endtask

  task automatic test_decerr();
    bdata[0] = 64'hDEAD_BEEF_0000_0001; bdata[1] = 64'hDEAD_BEEF_0000_0002;
    do_burst(32'd8184, 4'd1, 3'd3, 2'd1, 8'hFF, 1, 2'd3, 0);
    check_mem(1023, 64'hDEAD_BEEF_0000_0001);
    check_mem(0, 64'd0);
  endtask

  task automatic test_wlast_hold();
    for (int i = 0; i < 4; i++) bdata[i] = 64'h5000 + 64'(i);
    do_burst(32'h800, 4'd3, 3'd3, 2'd1, 8'hFF, 2, 2'd2, 5);
    check_mem(256, 64'h5000);
    check_mem(259, 64'h5003);
  endtask

  task automatic test_bad_bursts();
    for (int i = 0; i < 4; i++) bdata[i] = 64'hBAD0 + 64'(i);
    do_burst(32'h0, 4'd3, 3'd3, 2'd2, 8'hFF, 3, 2'd2, 0);   // WRAP: no write
    check_mem(0, 64'd0);
    do_burst(32'h10, 4'd1, 3'd4, 2'd1, 8'hFF, 1, 2'd2, 0);  // oversize: no write
    check_mem(2, 64'd2);
    bdata[0] = 64'h7770; bdata[1] = 64'h7771;
    do_burst(32'hFF8, 4'd1, 3'd3, 2'd1, 8'hFF, 1, 2'd2, 0); // 4KB cross, both in range
    check_mem(511, 64'h7770);
    check_mem(512, 64'h7771);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++) bdata[i] = 64'hC0DE_0000 + 64'(i);
    @(negedge clk);
    send_aw(32'h400, 4'd15, 3'd3, 2'd1);
    for (int i = 0; i < 5; i++) send_w(bdata[i], 8'hFF, 1'b0);
    wdata = bdata[5]; wstrb = 8'hFF; wvalid = 1'b1;
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b0 || burst_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid bvalid=%b awready=%b wready=%b burst_cnt=%0d required 0/1/0/0",
               bvalid, awready, wready, burst_cnt);
    end
    wvalid = 1'b0;
    rst = 1'b0;
    exp_bursts = 0; exp_errs = 0;
    @(negedge clk);
    $display("reset mid-burst applied");
    check_mem(128, 64'hC0DE_0000);
    check_mem(132, 64'hC0DE_0004);
    for (int i = 0; i < 4; i++) bdata[i] = 64'hE000 + 64'(i);
    do_burst(32'hC00, 4'd3, 3'd3, 2'd1, 8'hFF, 3, 2'd0, 0);
    check_mem(384, 64'hE000);
    check_mem(387, 64'hE003);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) bdata[i] = 64'hB2B0 + 64'(i);
    do_burst(32'h1000, 4'd1, 3'd3, 2'd1, 8'hFF, 1, 2'd0, 0);
    bdata[0] = 64'hB2B9;
    do_burst(32'h1010, 4'd0, 3'd3, 2'd1, 8'hFF, 0, 2'd0, 0);
    check_mem(513, 64'hB2B1);
    check_mem(514, 64'hB2B9);
  endtask

  initial begin
    test_reset();
    test_incr();
    test_fixed();
    test_strobe();
    test_decerr();
    test_wlast_hold();
    test_bad_bursts();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
